// File: rtl/memory_access_unit.sv
// Memory stage: performs the data-bus transaction for MIPS-style loads/stores,
// formats load results (including LWL/LWR merges) and raises AdEL/AdES.
module memory_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_kill,
    input  logic        flush,
    output logic        dbus_req,
    output logic [31:0] dbus_addr,
    output logic        dbus_wr,
    output logic [3:0]  dbus_strobe,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_adel,
    output logic        out_ades,
    output logic [31:0] out_badvaddr
);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LWL = 4'd3;
    localparam logic [3:0] OP_LWR = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_LHU = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd7;
    localparam logic [3:0] OP_SH  = 4'd8;
    localparam logic [3:0] OP_SW  = 4'd9;
    localparam logic [3:0] OP_SWL = 4'd10;
    localparam logic [3:0] OP_SWR = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    function automatic logic [3:0] store_strobe(input logic [3:0] op, input logic [1:0] a);
        logic [3:0] s;
        case (op)
            OP_SB:   s = 4'b0001 << a;
            OP_SH:   s = a[1] ? 4'b1100 : 4'b0011;
            OP_SW:   s = 4'b1111;
            OP_SWL: begin
                case (a)
                    2'd0:    s = 4'b0001;
                    2'd1:    s = 4'b0011;
                    2'd2:    s = 4'b0111;
                    default: s = 4'b1111;
                endcase
            end
            OP_SWR: begin
                case (a)
                    2'd0:    s = 4'b1111;
                    2'd1:    s = 4'b1110;
                    2'd2:    s = 4'b1100;
                    default: s = 4'b1000;
                endcase
            end
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [1:0] a,
                                               input logic [31:0] rt);
        logic [31:0] d;
        case (op)
            OP_SB:   d = {4{rt[7:0]}};
            OP_SH:   d = {2{rt[15:0]}};
            OP_SW:   d = rt;
            OP_SWL: begin
                case (a)
                    2'd0:    d = {24'h000000, rt[31:24]};
                    2'd1:    d = {16'h0000, rt[31:16]};
                    2'd2:    d = {8'h00, rt[31:8]};
                    default: d = rt;
                endcase
            end
            OP_SWR: begin
                case (a)
                    2'd0:    d = rt;
                    2'd1:    d = {rt[23:0], 8'h00};
                    2'd2:    d = {rt[15:0], 16'h0000};
                    default: d = {rt[7:0], 24'h000000};
                endcase
            end
            default: d = 32'h00000000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_format(input logic [3:0] op, input logic [1:0] a,
                                                input logic [31:0] rt, input logic [31:0] m);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = m[7:0];
            2'd1:    b = m[15:8];
            2'd2:    b = m[23:16];
            default: b = m[31:24];
        endcase
        h = a[1] ? m[31:16] : m[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LW:   r = m;
            OP_LWL: begin
                case (a)
                    2'd0:    r = {m[7:0], rt[23:0]};
                    2'd1:    r = {m[15:0], rt[15:0]};
                    2'd2:    r = {m[23:0], rt[7:0]};
                    default: r = m;
                endcase
            end
            OP_LWR: begin
                case (a)
                    2'd0:    r = m;
                    2'd1:    r = {rt[31:24], m[31:8]};
                    2'd2:    r = {rt[31:16], m[31:16]};
                    default: r = {rt[31:8], m[31:24]};
                endcase
            end
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [3:0]  op_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] rt_r;
    logic        dbus_wr_r;
    logic [31:0] dbus_addr_r;
    logic [3:0]  dbus_strobe_r;
    logic [31:0] dbus_wdata_r;
    logic [31:0] out_data_r;
    logic        adel_r;
    logic        ades_r;
    logic [31:0] badvaddr_r;
    logic        accept_s;
    logic        is_store_s;
    logic        misaligned_s;
    logic        fault_s;

    assign accept_s   = in_valid && (state_r == S_IDLE) && !flush;
    assign is_store_s = (in_op >= OP_SB);
    assign fault_s    = misaligned_s && !in_kill;

    // Alignment check; the unaligned-by-design ops (LWL/LWR/SWL/SWR, bytes) never fault.
    always_comb begin
        misaligned_s = 1'b0;
        case (in_op)
            OP_LH, OP_LHU, OP_SH: misaligned_s = in_addr[0];
            OP_LW, OP_SW:         misaligned_s = |in_addr[1:0];
            default:              misaligned_s = 1'b0;
        endcase
    end

    // Next-state logic for the bus transaction sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (in_kill || misaligned_s) begin
                        next_state_s = S_RESP;
                    end else begin
                        next_state_s = S_REQ;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (flush) begin
                    next_state_s = dbus_gnt ? S_DRAIN : S_IDLE;
                end else if (dbus_gnt) begin
                    next_state_s = S_WAIT;
                end else begin
                    next_state_s = S_REQ;
                end
            end
            S_WAIT: begin
                // A flush coinciding with rvalid has nothing left to drain.
                if (dbus_rvalid) begin
                    next_state_s = flush ? S_IDLE : S_RESP;
                end else if (flush) begin
                    next_state_s = S_DRAIN;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (dbus_rvalid) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_DRAIN;
                end
            end
            S_RESP:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State, latched request fields and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            op_r          <= 4'd0;
            addr_lo_r     <= 2'd0;
            rt_r          <= 32'h00000000;
            dbus_wr_r     <= 1'b0;
            dbus_addr_r   <= 32'h00000000;
            dbus_strobe_r <= 4'b0000;
            dbus_wdata_r  <= 32'h00000000;
            out_data_r    <= 32'h00000000;
            adel_r        <= 1'b0;
            ades_r        <= 1'b0;
            badvaddr_r    <= 32'h00000000;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                op_r          <= in_op;
                addr_lo_r     <= in_addr[1:0];
                rt_r          <= in_wdata;
                dbus_wr_r     <= is_store_s;
                dbus_addr_r   <= {in_addr[31:2], 2'b00};
                dbus_strobe_r <= store_strobe(in_op, in_addr[1:0]);
                dbus_wdata_r  <= store_data(in_op, in_addr[1:0], in_wdata);
                out_data_r    <= 32'h00000000;
                adel_r        <= fault_s && !is_store_s;
                ades_r        <= fault_s && is_store_s;
                badvaddr_r    <= fault_s ? in_addr : 32'h00000000;
            end else if ((state_r == S_WAIT) && dbus_rvalid) begin
                out_data_r <= dbus_wr_r ? 32'h00000000
                                        : load_format(op_r, addr_lo_r, rt_r, dbus_rdata);
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign in_ready     = (state_r == S_IDLE);
    assign dbus_req     = (state_r == S_REQ);
    assign dbus_addr    = dbus_addr_r;
    assign dbus_wr      = dbus_wr_r;
    assign dbus_strobe  = dbus_strobe_r;
    assign dbus_wdata   = dbus_wdata_r;
    assign out_valid    = (state_r == S_RESP) && !flush;
    assign out_data     = out_data_r;
    assign out_adel     = adel_r;
    assign out_ades     = ades_r;
    assign out_badvaddr = badvaddr_r;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic        in_kill = 1'b0;
    logic        flush = 1'b0;
    logic        dbus_req;
    logic [31:0] dbus_addr;
    logic        dbus_wr;
    logic [3:0]  dbus_strobe;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt = 1'b0;
    logic        dbus_rvalid = 1'b0;
    logic [31:0] dbus_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_adel;
    logic        out_ades;
    logic [31:0] out_badvaddr;

    int errors = 0;
    int checks = 0;

    int          obs_lat;
    logic        obs_req;
    logic        obs_stable;
    logic [31:0] obs_daddr;
    logic [3:0]  obs_strobe;
    logic [31:0] obs_wdata;
    logic        obs_wr;
    logic [31:0] obs_data;
    logic        obs_adel;
    logic        obs_ades;
    logic [31:0] obs_badv;

    memory_access_unit dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_kill(in_kill), .flush(flush),
        .dbus_req(dbus_req), .dbus_addr(dbus_addr), .dbus_wr(dbus_wr),
        .dbus_strobe(dbus_strobe), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_adel(out_adel),
        .out_ades(out_ades), .out_badvaddr(out_badvaddr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op and plays the bus side; gnt after gnt_delay REQ cycles, rvalid the cycle after.
    task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                             input logic kill, input int gnt_delay, input logic [31:0] rdata);
        int waited = 0;
        logic pend = 1'b0;
        obs_lat = 0; obs_req = 1'b0; obs_stable = 1'b1;
        obs_daddr = 32'h0; obs_strobe = 4'h0; obs_wdata = 32'h0; obs_wr = 1'b0;
        obs_data = 32'hX; obs_adel = 1'bX; obs_ades = 1'bX; obs_badv = 32'hX;
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = rt; in_kill = kill;
        tick();
        in_valid = 1'b0; in_kill = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
            if (out_valid) begin
                obs_lat = c; obs_data = out_data; obs_adel = out_adel;
                obs_ades = out_ades; obs_badv = out_badvaddr;
                break;
            end
            if (pend && !dbus_req) begin
                dbus_rvalid = 1'b1; dbus_rdata = rdata; pend = 1'b0;
            end
            if (dbus_req) begin
                if (!obs_req) begin
                    obs_daddr = dbus_addr; obs_strobe = dbus_strobe;
                    obs_wdata = dbus_wdata; obs_wr = dbus_wr;
                end else if (dbus_addr !== obs_daddr || dbus_strobe !== obs_strobe ||
                             dbus_wdata !== obs_wdata || dbus_wr !== obs_wr) begin
                    obs_stable = 1'b0;
                end
                obs_req = 1'b1;
                if (waited == gnt_delay) begin
                    dbus_gnt = 1'b1; pend = 1'b1;
                end else begin
                    waited++;
                end
            end
            tick();
        end
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        if (obs_lat != 0) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b1 || dbus_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b req=%b ov=%b, need 1 0 0", in_ready, dbus_req, out_valid);
        end
        checks++;
        if (dbus_wr !== 1'b0 || dbus_strobe !== 4'h0 || dbus_addr !== 32'h0 || dbus_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: wr=%b strb=%h addr=%h wd=%h, need all 0", dbus_wr, dbus_strobe, dbus_addr, dbus_wdata);
        end
        checks++;
        if (out_data !== 32'h0 || out_adel !== 1'b0 || out_ades !== 1'b0 || out_badvaddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: data=%h adel=%b ades=%b bad=%h, need all 0", out_data, out_adel, out_ades, out_badvaddr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_word();
        do_access(4'd2, 32'h0000_1000, 32'h0, 1'b0, 0, 32'hDEAD_BEEF);
        checks++;
        if (obs_daddr !== 32'h0000_1000 || obs_strobe !== 4'b0000 || obs_wr !== 1'b0) begin
            errors++;
            $display("FAIL lw_bus: addr=%h strb=%b wr=%b, need 00001000 0000 0", obs_daddr, obs_strobe, obs_wr);
        end
        checks++;
        if (obs_lat != 3) begin
            errors++;
            $display("FAIL lw_latency: got %0d need 3", obs_lat);
        end
        checks++;
        if (obs_data !== 32'hDEAD_BEEF || obs_adel !== 1'b0) begin
            errors++;
            $display("FAIL lw_data: got %h adel=%b need deadbeef 0", obs_data, obs_adel);
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b need 1 at T+4", in_ready);
        end
        do_access(4'd2, 32'h0000_1004, 32'h0, 1'b0, 0, 32'h0123_4567);
        checks++;
        if (obs_data !== 32'h0123_4567 || obs_lat != 3 || obs_daddr !== 32'h0000_1004) begin
            errors++;
            $display("FAIL b2b_lw: data=%h lat=%0d addr=%h need 01234567 3 00001004", obs_data, obs_lat, obs_daddr);
        end
    endtask

    task automatic test_load_subword();
        do_access(4'd0, 32'h0000_1003, 32'h0, 1'b0, 0, 32'h80FF_FF7F);
        checks++;
        if (obs_data !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_sext: got %h need ffffff80", obs_data);
        end
        do_access(4'd5, 32'h0000_1003, 32'h0, 1'b0, 0, 32'h80FF_FF7F);
        checks++;
        if (obs_data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu_zext: got %h need 00000080", obs_data);
        end
        do_access(4'd1, 32'h0000_1002, 32'h0, 1'b0, 1, 32'h80FF_1234);
        checks++;
        if (obs_data !== 32'hFFFF_80FF || obs_lat != 4) begin
            errors++;
            $display("FAIL lh_hi: got %h lat=%0d need ffff80ff 4", obs_data, obs_lat);
        end
        do_access(4'd6, 32'h0000_1000, 32'h0, 1'b0, 0, 32'h80FF_9234);
        checks++;
        if (obs_data !== 32'h0000_9234) begin
            errors++;
            $display("FAIL lhu_lo: got %h need 00009234", obs_data);
        end
    endtask

    task automatic test_stores();
        do_access(4'd10, 32'h0000_2001, 32'h1122_3344, 1'b0, 0, 32'hFFFF_FFFF);
        checks++;
        if (obs_strobe !== 4'b0011 || obs_wdata !== 32'h0000_1122 || obs_wr !== 1'b1 ||
            obs_daddr !== 32'h0000_2000 || obs_data !== 32'h0) begin
            errors++;
            $display("FAIL swl: strb=%b wd=%h wr=%b addr=%h data=%h need 0011 00001122 1 00002000 0",
                     obs_strobe, obs_wdata, obs_wr, obs_daddr, obs_data);
        end
        do_access(4'd11, 32'h0000_2002, 32'h1122_3344, 1'b0, 0, 32'h0);
        checks++;
        if (obs_strobe !== 4'b1100 || obs_wdata !== 32'h3344_0000) begin
            errors++;
            $display("FAIL swr: strb=%b wd=%h need 1100 33440000", obs_strobe, obs_wdata);
        end
        do_access(4'd7, 32'h0000_2003, 32'h1122_3344, 1'b0, 0, 32'h0);
        checks++;
        if (obs_strobe !== 4'b1000 || obs_wdata !== 32'h4444_4444) begin
            errors++;
            $display("FAIL sb: strb=%b wd=%h need 1000 44444444", obs_strobe, obs_wdata);
        end
        do_access(4'd8, 32'h0000_2002, 32'h1122_3344, 1'b0, 0, 32'h0);
        checks++;
        if (obs_strobe !== 4'b1100 || obs_wdata !== 32'h3344_3344) begin
            errors++;
            $display("FAIL sh: strb=%b wd=%h need 1100 33443344", obs_strobe, obs_wdata);
        end
    endtask

    task automatic test_merge_loads();
        do_access(4'd4, 32'h0000_3001, 32'hAABB_CCDD, 1'b0, 0, 32'h1122_3344);
        checks++;
        if (obs_data !== 32'hAA11_2233) begin
            errors++;
            $display("FAIL lwr_a1: got %h need aa112233", obs_data);
        end
        do_access(4'd3, 32'h0000_3001, 32'hAABB_CCDD, 1'b0, 0, 32'h1122_3344);
        checks++;
        if (obs_data !== 32'h3344_CCDD) begin
            errors++;
            $display("FAIL lwl_a1: got %h need 3344ccdd", obs_data);
        end
        do_access(4'd3, 32'h0000_3003, 32'hAABB_CCDD, 1'b0, 0, 32'h1122_3344);
        checks++;
        if (obs_data !== 32'h1122_3344 || obs_req !== 1'b1) begin
            errors++;
            $display("FAIL lwl_a3: got %h req=%b need 11223344 1", obs_data, obs_req);
        end
    endtask

    task automatic test_faults();
        do_access(4'd1, 32'h0000_4001, 32'h0, 1'b0, 0, 32'h0);
        checks++;
        if (obs_lat != 1 || obs_adel !== 1'b1 || obs_ades !== 1'b0 ||
            obs_badv !== 32'h0000_4001 || obs_req !== 1'b0 || obs_data !== 32'h0) begin
            errors++;
            $display("FAIL adel_lh: lat=%0d adel=%b ades=%b bad=%h req=%b data=%h need 1 1 0 00004001 0 0",
                     obs_lat, obs_adel, obs_ades, obs_badv, obs_req, obs_data);
        end
        do_access(4'd9, 32'h0000_4002, 32'h5555_5555, 1'b0, 0, 32'h0);
        checks++;
        if (obs_lat != 1 || obs_ades !== 1'b1 || obs_adel !== 1'b0 ||
            obs_badv !== 32'h0000_4002 || obs_req !== 1'b0) begin
            errors++;
            $display("FAIL ades_sw: lat=%0d ades=%b adel=%b bad=%h req=%b need 1 1 0 00004002 0",
                     obs_lat, obs_ades, obs_adel, obs_badv, obs_req);
        end
        do_access(4'd1, 32'h0000_4001, 32'h0, 1'b1, 0, 32'h0);
        checks++;
        if (obs_lat != 1 || obs_adel !== 1'b0 || obs_ades !== 1'b0 ||
            obs_req !== 1'b0 || obs_data !== 32'h0) begin
            errors++;
            $display("FAIL kill: lat=%0d adel=%b ades=%b req=%b data=%h need 1 0 0 0 0",
                     obs_lat, obs_adel, obs_ades, obs_req, obs_data);
        end
    endtask

    task automatic test_flush();
        logic bad = 1'b0;
        in_valid = 1'b1; in_op = 4'd2; in_addr = 32'h0000_5000; in_kill = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (dbus_req !== 1'b1 || dbus_addr !== 32'h0000_5000 || dbus_wr !== 1'b0 || dbus_strobe !== 4'h0)
                bad = 1'b1;
            tick();
        end
        checks++;
        if (bad || dbus_req !== 1'b1) begin
            errors++;
            $display("FAIL req_hold: req=%b addr=%h unstable=%b need 1 00005000 0", dbus_req, dbus_addr, bad);
        end
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt = 1'b0; flush = 1'b1;
        checks++;
        if (dbus_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_state: req=%b ov=%b need 0 0", dbus_req, out_valid);
        end
        tick();
        flush = 1'b0;
        tick();
        dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold: ready=%b ov=%b need 0 0", in_ready, out_valid);
        end
        tick();
        dbus_rvalid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: ready=%b ov=%b need 1 0", in_ready, out_valid);
        end
        // flush in REQ without gnt returns straight to IDLE
        in_valid = 1'b1; in_op = 4'd2; in_addr = 32'h0000_5004;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || dbus_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_req: ready=%b req=%b need 1 0", in_ready, dbus_req);
        end
        // flush in IDLE blocks the accept
        in_valid = 1'b1; in_op = 4'd1; in_addr = 32'h0000_5001; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: ready=%b ov=%b need 1 0", in_ready, out_valid);
        end
        // flush in RESP suppresses the pulse
        in_valid = 1'b1; in_op = 4'd1; in_addr = 32'h0000_5001;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp: ov=%b ready=%b need 0 0", out_valid, in_ready);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_resp_exit: ready=%b ov=%b need 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_op = 4'd9; in_addr = 32'h0000_6000; in_wdata = 32'hCAFE_F00D;
        tick();
        in_valid = 1'b0;
        checks++;
        if (dbus_req !== 1'b1 || dbus_wdata !== 32'hCAFE_F00D || dbus_strobe !== 4'b1111) begin
            errors++;
            $display("FAIL sw_req: req=%b wd=%h strb=%b need 1 cafef00d 1111", dbus_req, dbus_wdata, dbus_strobe);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (dbus_req !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req: req=%b ready=%b need 0 1", dbus_req, in_ready);
        end
        dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        tick();
        dbus_rvalid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_rvalid: ov=%b ready=%b need 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_word();
        test_back_to_back();
        test_load_subword();
        test_stores();
        test_merge_loads();
        test_faults();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage counterpart of the execute ALU. It accepts the effective address the ALU produces for LB/LH/LW/LWL/LWR/LBU/LHU/SB/SH/SW/SWL/SWR, performs the data-bus transaction, and returns the aligned, extended or merged load result to writeback. It also raises address-error exceptions (AdEL/AdES). It sits between execute and writeback and stalls the pipeline while a bus transaction is outstanding.

## Interface
- Parameters: none. All datapaths are fixed at 32 bits (word_t).
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute presents a memory op
- in_ready  out  1  unit idle and accepting; the op is taken when in_valid && in_ready
- in_op  in  4  0=LB 1=LH 2=LW 3=LWL 4=LWR 5=LBU 6=LHU 7=SB 8=SH 9=SW 10=SWL 11=SWR; codes 12-15 are never presented
- in_addr  in  32  effective address from the ALU
- in_wdata  in  32  rt value: store data, and merge source for LWL/LWR
- in_kill  in  1  an exception is already pending: no bus access, no new exception
- flush  in  1  abandon the current op and produce no output
- dbus_req  out  1  bus request
- dbus_addr  out  32  word address, {addr[31:2],2'b00}
- dbus_wr  out  1  1 for stores
- dbus_strobe  out  4  byte enables; 0 for loads
- dbus_wdata  out  32  lane-positioned store data
- dbus_gnt  in  1  request accepted this cycle
- dbus_rvalid  in  1  read data or write ack; arrives no earlier than the cycle after dbus_gnt
- dbus_rdata  in  32  read data
- out_valid  out  1  one-cycle completion pulse
- out_data  out  32  load result; 0 for stores, kills and exceptions
- out_adel / out_ades  out  1  load / store address error, qualified by out_valid
- out_badvaddr  out  32  faulting address, qualified by out_adel|out_ades

## Operation
- States: IDLE, REQ, WAIT, DRAIN, RESP. Reset enters IDLE.
- IDLE: in_ready=1. On accept, latch op, addr, wdata and kill.
  - kill set: go to RESP with no exception flags and out_data=0.
  - Misaligned address: halfword op (LH, LHU, SH) with addr[0]=1, or word op (LW, SW) with addr[1:0]!=0. Go to RESP with out_adel (loads) or out_ades (stores) and out_badvaddr=addr.
  - Otherwise go to REQ.
  - LWL, LWR, SWL, SWR, LB, LBU and SB never fault.
- REQ: dbus_req=1. dbus_addr, dbus_wr, dbus_strobe and dbus_wdata stay stable until dbus_gnt. On dbus_gnt go to WAIT.
- WAIT: on dbus_rvalid, capture the formatted result and go to RESP.
- RESP: out_valid=1 for exactly one cycle, then go to IDLE.
- flush:
  - In REQ without gnt that cycle: go to IDLE.
  - In REQ with gnt, or in WAIT: go to DRAIN, which waits for dbus_rvalid and then goes to IDLE with no out_valid.
  - In RESP: suppress out_valid.
  - In IDLE: suppress the accept.
- Store strobes, with a = addr[1:0], little-endian:
  - SB: 1<<a
  - SH: a[1] ? 1100 : 0011
  - SW: 1111
  - SWL: a=0 → 0001, a=1 → 0011, a=2 → 0111, a=3 → 1111
  - SWR: a=0 → 1111, a=1 → 1110, a=2 → 1100, a=3 → 1000
- Store data:
  - SB: {4{rt[7:0]}}
  - SH: {2{rt[15:0]}}
  - SW: rt
  - SWL: rt >> 8*(3-a)
  - SWR: rt << 8*a
- Load formatting, with m = dbus_rdata:
  - LB/LBU: byte m[8a+7:8a], sign- or zero-extended.
  - LH/LHU: halfword selected by a[1], sign- or zero-extended.
  - LW: m.
  - LWL: a=0 → {m[7:0],rt[23:0]}; a=1 → {m[15:0],rt[15:0]}; a=2 → {m[23:0],rt[7:0]}; a=3 → m.
  - LWR: a=0 → m; a=1 → {rt[31:24],m[31:8]}; a=2 → {rt[31:16],m[31:16]}; a=3 → {rt[31:8],m[31:24]}.

## Timing
- Reset values: state IDLE, in_ready=1, dbus_req=0, dbus_wr=0, dbus_strobe=0, dbus_addr=0, dbus_wdata=0, out_valid=0, out_data=0, out_adel=0, out_ades=0, out_badvaddr=0.
- Reset mid-transaction returns to IDLE on the next edge and drops dbus_req. A stray dbus_rvalid arriving in IDLE is ignored.
- Best-case latency, accept at cycle T:
  - REQ at T+1 with gnt.
  - WAIT at T+2 with rvalid.
  - out_valid at T+3.
  - Next accept possible at T+4.
- Fault or kill: out_valid at T+1, no dbus_req at any point.
- dbus_gnt and dbus_rvalid outside REQ, WAIT and DRAIN are ignored.
- out_data and the exception flags are registered and are valid only in the out_valid cycle.

## Test plan
- LW addr=0x1000, gnt at T+1, rdata=0xDEADBEEF at T+2 → dbus_addr=0x1000, strobe=0000, out_valid at T+3, out_data=0xDEADBEEF.
- LB addr=0x1003, rdata=0x80FF_FF7F → out_data=0xFFFFFF80. The same access as LBU → 0x00000080.
- SWL addr=0x2001, rt=0x11223344 → strobe=0011, wdata=0x00001122, out_data=0. SWR addr=0x2002 → strobe=1100, wdata=0x33440000.
- LWR addr=0x3001, rt=0xAABBCCDD, rdata=0x11223344 → out_data=0xAA112233.
- LH addr=0x4001 → out_valid at T+1, out_adel=1, out_badvaddr=0x4001, dbus_req never asserted. SW addr=0x4002 → out_ades=1.
- Flush and reset cases:
  - gnt withheld 5 cycles (request held stable throughout), then flush in WAIT → no out_valid; rvalid drains; in_ready returns the cycle after rvalid.
  - Reset asserted in REQ → dbus_req=0 and in_ready=1 the next cycle.
